// File: rtl/graph_plotter.sv
// Polyline rasteriser: maps NPTS Q16.16 points to screen space and draws the
// NPTS-1 connecting segments with Bresenham, clipping off-screen pixels.
module graph_plotter #(
  parameter int NPTS  = 64,
  parameter int X_OFF = 320,
  parameter int Y_OFF = 240,
  parameter int SCR_W = 640,
  parameter int SCR_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] xs [NPTS],
  input  logic [31:0] ys [NPTS],
  input  logic        complete,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        busy,
  output logic        done
);

  localparam int IW = (NPTS > 2) ? $clog2(NPTS) : 1;
  localparam logic [IW-1:0] LAST_SEG = IW'(NPTS - 2);

  typedef enum logic [1:0] {IDLE, LOAD, LINE, DONE} state_t;

  state_t state, state_nxt;

  logic                 complete_q;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_p1;
  logic signed [32:0]   x, y, x1, y1, dx, dy, err;
  logic                 x_neg, y_neg;

  logic signed [32:0]   lx0, ly0, lx1, ly1, ldx, ldy;
  logic signed [33:0]   e2;
  logic                 in_range, at_end, advance, step_x, step_y;

  function automatic logic signed [32:0] map_x(input logic [31:0] v);
    logic signed [31:0] t;
    t = ($signed(v) >>> 16) + X_OFF;
    return {t[31], t};
  endfunction

  function automatic logic signed [32:0] map_y(input logic [31:0] v);
    logic signed [31:0] t;
    t = Y_OFF - ($signed(v) >>> 16);
    return {t[31], t};
  endfunction

  // Endpoints of segment idx are read straight from the stable input arrays.
  always_comb begin
    idx_p1 = idx + 1'b1;
    lx0    = map_x(xs[idx]);
    ly0    = map_y(ys[idx]);
    lx1    = map_x(xs[idx_p1]);
    ly1    = map_y(ys[idx_p1]);
    ldx    = (lx1 >= lx0) ? (lx1 - lx0) : (lx0 - lx1);
    ldy    = (ly1 >= ly0) ? (ly0 - ly1) : (ly1 - ly0);
  end

  always_comb begin
    in_range = !x[32] && (x < 33'(SCR_W)) && !y[32] && (y < 33'(SCR_H));
    at_end   = (x == x1) && (y == y1);
    advance  = (state == LINE) && (!in_range || pix_ready);
    e2       = {err, 1'b0};
    step_x   = (e2 >= dy);
    step_y   = (e2 <= dx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (complete && !complete_q) state_nxt = LOAD;
      LOAD: state_nxt = LINE;
      LINE: if (advance && at_end) state_nxt = (idx != LAST_SEG) ? LOAD : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      complete_q <= 1'b0;
      idx        <= '0;
      x          <= '0;
      y          <= '0;
      x1         <= '0;
      y1         <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      x_neg      <= 1'b0;
      y_neg      <= 1'b0;
    end else begin
      complete_q <= complete;
      unique case (state)
        IDLE: idx <= '0;
        LOAD: begin
          x     <= lx0;
          y     <= ly0;
          x1    <= lx1;
          y1    <= ly1;
          dx    <= ldx;
          dy    <= ldy;
          err   <= ldx + ldy;
          x_neg <= (lx1 < lx0);
          y_neg <= (ly1 < ly0);
        end
        LINE: begin
          if (advance) begin
            if (at_end) begin
              if (idx != LAST_SEG) idx <= idx_p1;
            end else begin
              // Both axis decisions use the pre-step error, as in the textbook loop.
              if (step_x) x <= x_neg ? (x - 33'sd1) : (x + 33'sd1);
              if (step_y) y <= y_neg ? (y - 33'sd1) : (y + 33'sd1);
              err <= err + (step_x ? dy : 33'sd0) + (step_y ? dx : 33'sd0);
            end
          end
        end
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    pix_valid = (state == LINE) && in_range;
    pix_x     = x[9:0];
    pix_y     = y[8:0];
    busy      = (state == LOAD) || (state == LINE);
    done      = (state == DONE);
  end

endmodule

// File: doc/graph_plotter.md
GRAPH_PLOTTER -- requirements
Module: graph_plotter

Interface
REQ-001 Parameter NPTS, default 64: number of input points; draws NPTS-1 segments.
REQ-002 Parameter X_OFF, default 320: screen x of origin.
REQ-003 Parameter Y_OFF, default 240: screen y of origin.
REQ-004 Parameter SCR_W, default 640; parameter SCR_H, default 480: visible area.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 xs  input  32 x NPTS  point x, signed Q16.16; index 0 first.
REQ-008 ys  input  32 x NPTS  point y, signed Q16.16.
REQ-009 complete  input  1  upstream graph stage result valid; xs/ys stable while high.
REQ-010 pix_valid  output  1  pix_x/pix_y hold a pixel to write.
REQ-011 pix_ready  input  1  pixel sink accepts; transfer when pix_valid and pix_ready both high.
REQ-012 pix_x  output  10  screen column; pix_y  output  9  screen row.
REQ-013 busy  output  1  high from start until done.
REQ-014 done  output  1  one-cycle pulse when all segments are drawn.

Function
REQ-015 Start: in IDLE, complete high while its registered copy is low (rising edge) -> LOAD next cycle; complete held high never retriggers.
REQ-016 complete edges while busy are ignored; xs/ys are read directly and must stay stable while busy.
REQ-017 Mapping: sx = (xs[k] >>> 16) + X_OFF, sy = Y_OFF - (ys[k] >>> 16), both 32-bit signed arithmetic, truncating toward minus infinity.
REQ-018 States: IDLE, LOAD, LINE, DONE.
REQ-019 LOAD (1 cycle): latch endpoints of segment i (point i to i+1); compute dx=|x1-x0|, dy=-|y1-y0|, step signs, err=dx+dy; -> LINE.
REQ-020 LINE: Bresenham, one candidate pixel per step, start point and end point both included.
REQ-021 In-range candidate (0<=sx<SCR_W, 0<=sy<SCR_H): pix_valid high; step advances only on the transfer cycle.
REQ-022 Out-of-range candidate: pix_valid low; step advances in 1 cycle; the candidate is never emitted (clipping).
REQ-023 pix_x, pix_y and pix_valid stay constant while pix_valid high and pix_ready low.
REQ-024 Step: e2=2*err; if e2>=dy then err+=dy, x+=sx_step; if e2<=dx then err+=dx, y+=sy_step.
REQ-025 Segment end: step at (x1,y1) completes; if i<NPTS-2 then i++ and -> LOAD, else -> DONE.
REQ-026 Shared endpoints between adjacent segments are emitted twice; duplicates are allowed.
REQ-027 Degenerate segment (identical endpoints) emits exactly one candidate.
REQ-028 DONE: done=1 for one cycle, busy=0 the same cycle; -> IDLE.
REQ-029 busy=1 in LOAD and LINE, 0 in IDLE and DONE.
REQ-030 Internal coordinate/error registers are 33-bit signed; no overflow for Q16.16 inputs.

Reset
REQ-031 rst high: immediately -> IDLE; pix_valid=0, busy=0, done=0, pix_x=0, pix_y=0, i=0, registered complete=0.
REQ-032 Reset mid-draw aborts with no done pulse; after release, a new rising edge of complete is required to start.
REQ-033 If complete is already high at reset release, the first cycle counts as a rising edge.

Verification
REQ-034 Reset: rst=1 mid-LINE with pix_valid=1 -> pix_valid=0, busy=0 asynchronously; no done pulse follows.
REQ-035 Flat line: xs[k]=k<<16, ys[k]=0, pix_ready=1 -> 126 transfers, y=240, x from 320..383 ascending, each interior x twice; done pulses exactly once; complete held high -> no second run.
REQ-036 Degenerate: all points (0,0) -> 63 transfers of (320,240), then done.
REQ-037 Backpressure: pix_ready toggled randomly -> transfer sequence identical to the pix_ready=1 run; outputs stable while stalled.
REQ-038 Clipping: segment from (-400,0) to (-300,0) screen-relative (sx -80..20) -> only sx 0..20 emitted; busy stays high through the clipped steps.
REQ-039 Diagonal: points alternate (0,0),(5,5) -> each segment emits 6 pixels, with x and y both changing every step.
